decode_stage: RTL

- RV32I instruction-decode stage. Sits between fetch and execute, directly upstream of the register file.
- Drives the register-file read addresses from the incoming instruction.
- Because the register file registers its read data, the stage captures decoded fields on the same edge. Those fields emerge aligned with the register-file outputs.
- Also provides write-back bypass, immediate generation, valid/ready handshaking, flush, and load-use interlock.

---
 rtl/rv32_pkg.sv | 63 ++++++
 rtl/imm_gen.sv | 45 ++++
 rtl/decode_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions.
//   - register-address width
//   - base opcode constants
//   - OpClass encoding seen on decode_stage.o_OpClass
//   - immediate-format enum produced by imm_gen
//   - op_class(): opcode -> OpClass; any opcode not listed is ILLEGAL
package rv32_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_ILLEGAL = 4'd10
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic opclass_e op_class(input logic [6:0] opcode);
    opclass_e cls;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator (purely combinational).
// Ports:
//   instr  in   32  instruction word
//   imm    out  32  sign-extended immediate (0 for formats without one)
//   fmt    out   3  immediate format selected from the opcode
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  always_comb begin
    fmt = IMM_NONE;
    imm = '0;
    case (op_class(instr[6:0]))
      CLS_OPIMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM: begin
        fmt = IMM_I;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      CLS_STORE: begin
        fmt = IMM_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      CLS_BRANCH: begin
        fmt = IMM_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      CLS_LUI, CLS_AUIPC: begin
        fmt = IMM_U;
        imm = {instr[31:12], 12'b0};
      end
      CLS_JAL: begin
        fmt = IMM_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt = IMM_NONE;
        imm = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage between fetch and execute, in front of a register file
// whose read data is registered. Decoded fields are captured on the same edge
// the register file samples o_Rs1/o_Rs2, so both appear together one cycle
// after acceptance.
// Ports:
//   i_Clk, i_Rst (async, active-low)
//   fetch side   : i_Valid, o_Ready, i_Instr, i_PC
//   regfile side : o_Rs1, o_Rs2, i_RData0, i_RData1
//   write-back   : i_WbWE, i_WbRd, i_WbData
//   control      : i_Flush
//   execute side : o_Valid, i_Ready, o_PC, o_Op1, o_Op2, o_Imm, o_Rd,
//                  o_Funct3, o_Funct7b5, o_OpClass, o_IsLoad, o_RegWE, o_Illegal
module decode_stage
  import rv32_pkg::*;
#(
  parameter int          LOAD_USE_STALL = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [31:0]       i_Instr,
  input  logic [31:0]       i_PC,
  output logic [REG_AW-1:0] o_Rs1,
  output logic [REG_AW-1:0] o_Rs2,
  input  logic [31:0]       i_RData0,
  input  logic [31:0]       i_RData1,
  input  logic              i_WbWE,
  input  logic [REG_AW-1:0] i_WbRd,
  input  logic [31:0]       i_WbData,
  input  logic              i_Flush,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [31:0]       o_PC,
  output logic [31:0]       o_Op1,
  output logic [31:0]       o_Op2,
  output logic [31:0]       o_Imm,
  output logic [REG_AW-1:0] o_Rd,
  output logic [2:0]        o_Funct3,
  output logic              o_Funct7b5,
  output logic [3:0]        o_OpClass,
  output logic              o_IsLoad,
  output logic              o_RegWE,
  output logic              o_Illegal
);

  // Stall windows longer than 15 cycles are not meaningful for this pipeline.
  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_USE_STALL);

  opclass_e          in_class;
  imm_fmt_e          in_fmt;
  logic [31:0]       in_imm;
  logic              in_use_rs1;
  logic              in_use_rs2;
  logic              in_writes;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;

  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] ld_rd_q;
  logic [CNT_W-1:0]  ld_cnt_q;
  logic              byp1_q;
  logic              byp2_q;
  logic [31:0]       byp_data_q;

  logic hazard;
  logic acc;
  logic dispatch_load;

  imm_gen u_imm_gen (
    .instr (i_Instr),
    .imm   (in_imm),
    .fmt   (in_fmt)
  );

  assign in_class = op_class(i_Instr[6:0]);
  assign in_rd    = i_Instr[11:7];

  // Every I-format class reads rs1 only; R/S/B read both; U/J/illegal read none.
  always_comb begin
    in_use_rs2 = (in_class == CLS_BRANCH) || (in_class == CLS_STORE) || (in_class == CLS_OP);
    in_use_rs1 = in_use_rs2 || (in_fmt == IMM_I);
    in_writes  = (in_class == CLS_LUI)   || (in_class == CLS_AUIPC) ||
                 (in_class == CLS_JAL)   || (in_class == CLS_JALR)  ||
                 (in_class == CLS_LOAD)  || (in_class == CLS_OPIMM) ||
                 (in_class == CLS_OP)    ||
                 ((in_class == CLS_SYSTEM) && (i_Instr[14:12] != 3'b000));
  end

  // Unused sources point at x0 so they can never bypass or raise a hazard.
  assign in_rs1 = in_use_rs1 ? i_Instr[19:15] : '0;
  assign in_rs2 = in_use_rs2 ? i_Instr[24:20] : '0;

  assign hazard = (ld_cnt_q != '0) && i_Valid &&
                  ((in_use_rs1 && (in_rs1 == ld_rd_q)) ||
                   (in_use_rs2 && (in_rs2 == ld_rd_q)));

  assign o_Ready = (!o_Valid || i_Ready) && !hazard;
  assign acc     = i_Valid && o_Ready && !i_Flush;

  // While stalled the held sources are re-read every cycle, which keeps the
  // register-file output tracking write-backs to those registers.
  assign o_Rs1 = acc ? in_rs1 : rs1_q;
  assign o_Rs2 = acc ? in_rs2 : rs2_q;

  // The bypass covers the edge where the register file returns the pre-write value.
  assign o_Op1 = byp1_q ? byp_data_q : i_RData0;
  assign o_Op2 = byp2_q ? byp_data_q : i_RData1;

  assign dispatch_load = o_Valid && i_Ready && o_IsLoad && o_RegWE;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Valid    <= 1'b0;
      o_PC       <= RESET_PC;
      o_Imm      <= '0;
      o_Rd       <= '0;
      o_Funct3   <= '0;
      o_Funct7b5 <= 1'b0;
      o_OpClass  <= '0;
      o_IsLoad   <= 1'b0;
      o_RegWE    <= 1'b0;
      o_Illegal  <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
      ld_rd_q    <= '0;
      ld_cnt_q   <= '0;
    end else begin
      if (i_Flush)                o_Valid <= 1'b0;
      else if (acc)               o_Valid <= 1'b1;
      else if (o_Valid && i_Ready) o_Valid <= 1'b0;

      if (acc) begin
        o_PC       <= i_PC;
        o_Imm      <= in_imm;
        o_Rd       <= in_rd;
        o_Funct3   <= i_Instr[14:12];
        o_Funct7b5 <= i_Instr[30];
        o_OpClass  <= in_class;
        o_IsLoad   <= (in_class == CLS_LOAD);
        o_RegWE    <= in_writes && (in_rd != '0);
        o_Illegal  <= (in_class == CLS_ILLEGAL);
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
      end

      byp1_q     <= i_WbWE && (i_WbRd == o_Rs1) && (o_Rs1 != '0);
      byp2_q     <= i_WbWE && (i_WbRd == o_Rs2) && (o_Rs2 != '0);
      byp_data_q <= i_WbData;

      // A flushed pipeline still lets an already-dispatched load finish,
      // so the window keeps counting through flush.
      if (dispatch_load) begin
        ld_rd_q  <= o_Rd;
        ld_cnt_q <= STALL_INIT;
      end else if (ld_cnt_q != '0) begin
        ld_cnt_q <= ld_cnt_q - 1'b1;
      end
    end
  end

endmodule
